// File: rtl/tiny_tdc_pkg.sv
// Shared definitions for the TDC packetizer slice.
//   SYNC_BYTE    : first byte of every packet
//   pkt_state_e  : packetizer FSM states
//   nbytes()     : payload byte count for a given sample width
//   payload_byte : selects payload byte k (0 = most significant) of a zero-extended word
//   chk_byte     : packet checksum, XOR of SEQ and every payload byte
package tiny_tdc_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        OFFER = 3'd2,
        HOLD  = 3'd3,
        REARM = 3'd4
    } pkt_state_e;

    function automatic int nbytes(input int width);
        return (width + 32'sd7) / 32'sd8;
    endfunction

    // Only meaningful for 0 <= k < nb; byte 0 is the most significant payload byte.
    function automatic logic [7:0] payload_byte(input logic [31:0] payload, input int nb, input int k);
        logic [31:0] shifted;
        shifted = payload >> (32'sd8 * (nb - 32'sd1 - k));
        return shifted[7:0];
    endfunction

    function automatic logic [7:0] chk_byte(input logic [7:0] seq, input logic [31:0] payload, input int nb);
        logic [7:0] acc;
        acc = seq;
        for (int k = 0; k < 32'sd4; k++) begin
            if (k < nb) begin
                acc = acc ^ payload_byte(payload, nb, k);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push/din : write request and data; a push while full is accepted only
//              when a pop happens in the same cycle
//   pop/dout : read request; dout shows the head entry whenever !empty
//   full, empty : occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
            end
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/tdc_packetizer.sv
// Frames TDC samples into byte packets for a UART serializer:
//   SYNC(0xA5), SEQ, payload MSB first, CHK (XOR of SEQ and payload).
//   clk, rst          : clock, asynchronous active-high reset
//   sample_valid/data : one-cycle strobe and measurement word
//   out_valid/ready/data : byte handshake towards the serializer
//   busy              : packet in flight
//   overflow          : sticky, a sample was dropped on a full FIFO
//   drop_count        : dropped samples, saturating at 255
// Every byte is held on out_data until the serializer has dropped and
// re-raised out_ready, so it stays stable for the whole shift-out.
module tdc_packetizer
    import tiny_tdc_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                busy,
    output logic                overflow,
    output logic [7:0]          drop_count
);
    localparam int         NB       = nbytes(SAMPLE_W);
    localparam logic [2:0] LAST_IDX = 3'(NB + 2);

    pkt_state_e          state_r, state_s;
    logic [31:0]         hold_r, hold_s;
    logic [7:0]          chk_r, chk_s;
    logic [7:0]          seq_r, seq_s;
    logic [2:0]          idx_r, idx_s;
    logic                out_valid_r, out_valid_s;
    logic [7:0]          out_data_r, out_data_s;
    logic                busy_r, busy_s;
    logic                overflow_r, overflow_s;
    logic [7:0]          drop_count_r, drop_count_s;
    logic [7:0]          cur_byte_s;
    logic                fifo_pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [SAMPLE_W-1:0] fifo_dout_s;
    logic                drop_s;

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_valid),
        .pop   (fifo_pop_s),
        .din   (sample_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // A full FIFO still takes the sample if the FSM pops in the same cycle.
    assign drop_s = sample_valid && fifo_full_s && !fifo_pop_s;

    // Byte selected by the current packet index.
    always_comb begin
        cur_byte_s = 8'h00;
        if (idx_r == 3'd0) begin
            cur_byte_s = SYNC_BYTE;
        end else if (idx_r == 3'd1) begin
            cur_byte_s = seq_r;
        end else if (idx_r == LAST_IDX) begin
            cur_byte_s = chk_r;
        end else begin
            cur_byte_s = payload_byte(hold_r, NB, int'(idx_r) - 32'sd2);
        end
    end

    // Packet FSM: next state and next register values.
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        chk_s       = chk_r;
        seq_s       = seq_r;
        idx_s       = idx_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        busy_s      = busy_r;
        fifo_pop_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    hold_s     = 32'(fifo_dout_s);
                    chk_s      = chk_byte(seq_r, 32'(fifo_dout_s), NB);
                    idx_s      = 3'd0;
                    busy_s     = 1'b1;
                    state_s    = LOAD;
                end else begin
                    busy_s = 1'b0;
                end
            end
            LOAD: begin
                out_data_s = cur_byte_s;
                state_s    = OFFER;
            end
            OFFER: begin
                if (out_valid_r && out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = HOLD;
                    if (idx_r == LAST_IDX) begin
                        seq_s = seq_r + 8'd1;
                    end else begin
                        seq_s = seq_r;
                    end
                end else if (out_ready) begin
                    out_valid_s = 1'b1;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            HOLD: begin
                // Serializer must acknowledge by dropping ready before the next byte.
                if (!out_ready) begin
                    state_s = REARM;
                end else begin
                    state_s = HOLD;
                end
            end
            REARM: begin
                if (out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        busy_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = LOAD;
                    end
                end else begin
                    state_s = REARM;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // Overflow flag and saturating drop counter.
    always_comb begin
        overflow_s   = overflow_r;
        drop_count_s = drop_count_r;
        if (drop_s) begin
            overflow_s = 1'b1;
            if (drop_count_r != 8'hFF) begin
                drop_count_s = drop_count_r + 8'd1;
            end else begin
                drop_count_s = drop_count_r;
            end
        end else begin
            overflow_s   = overflow_r;
            drop_count_s = drop_count_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            hold_r       <= 32'h0;
            chk_r        <= 8'h00;
            seq_r        <= 8'h00;
            idx_r        <= 3'd0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'h00;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= 8'h00;
        end else begin
            state_r      <= state_s;
            hold_r       <= hold_s;
            chk_r        <= chk_s;
            seq_r        <= seq_s;
            idx_r        <= idx_s;
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            busy_r       <= busy_s;
            overflow_r   <= overflow_s;
            drop_count_r <= drop_count_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_tdc_packetizer.sv
// Bench for tdc_packetizer: a packet-level reference model (queue of expected
// bytes built from accepted samples), one compare process on every transfer,
// a serializer model driving out_ready, and directed plus random stimulus.
module tb_tdc_packetizer;
    localparam int SAMPLE_W   = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int NB         = (SAMPLE_W + 7) / 8;
    localparam int PKT_LEN    = NB + 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_data = '0;
    logic                out_ready = 1'b0;
    logic                out_valid;
    logic [7:0]          out_data;
    logic                busy;
    logic                overflow;
    logic [7:0]          drop_count;

    tdc_packetizer #(.SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         accepted = 0;
    int         completed = 0;
    int         byte_pos = 0;
    logic [7:0] model_seq = 8'h00;
    int         ser_mode = 1;   // 0 serializer model, 1 ready low, 2 ready high, other random

    logic [7:0] lit_a [5] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h26};
    logic [7:0] lit_b [5] = '{8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h50};
    logic [7:0] lit_c [5] = '{8'hA5, 8'h00, 8'h00, 8'hFF, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected packet for an accepted sample, straight from the framing rules.
    function automatic void model_push(input logic [SAMPLE_W-1:0] s);
        logic [31:0] v;
        logic [31:0] b;
        logic [7:0]  c;
        v = 32'(s);
        c = model_seq;
        exp_q.push_back(8'hA5);
        exp_q.push_back(model_seq);
        for (int i = 0; i < NB; i++) begin
            b = v >> (8 * (NB - 1 - i));
            exp_q.push_back(b[7:0]);
            c = c ^ b[7:0];
        end
        exp_q.push_back(c);
        model_seq = model_seq + 8'd1;
        accepted++;
    endfunction

    function automatic void clear_model();
        exp_q.delete();
        got_q.delete();
        accepted  = 0;
        completed = 0;
        byte_pos  = 0;
        model_seq = 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [SAMPLE_W-1:0] d, input bit accept);
        sample_valid = 1'b1;
        sample_data  = d;
        if (accept) model_push(d);
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check("wait_bytes_timeout", 32'(got_q.size() >= n), 32'd1);
    endtask

    // Serializer model: ready drops one cycle after a transfer, stays low 8 cycles.
    initial begin
        int dly;
        int low;
        bit t;
        dly = 0;
        low = 0;
        forever begin
            @(negedge clk);
            t = out_valid && out_ready && !rst;
            @(posedge clk);
            #2;
            case (ser_mode)
                0: begin
                    if (t) begin
                        dly = 1;
                    end else if (dly == 1) begin
                        dly = 0;
                        low = 8;
                        out_ready = 1'b0;
                    end else if (low > 0) begin
                        low--;
                        if (low == 0) out_ready = 1'b1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                1: begin out_ready = 1'b0; dly = 0; low = 0; end
                2: begin out_ready = 1'b1; dly = 0; low = 0; end
                default: begin out_ready = ($urandom_range(0, 2) != 0); dly = 0; low = 0; end
            endcase
        end
    end

    // Compare process: byte stream against the model, hold rule, busy coherence.
    initial begin
        logic [7:0] prev_data;
        logic       prev_valid;
        bit         have_prev;
        have_prev = 0;
        prev_data = 8'h00;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 0;
            end else begin
                if (have_prev && out_data !== prev_data)
                    check("hold_rule_valid_at_change", 32'({prev_valid, out_valid}), 32'd0);
                if (out_valid) check("busy_while_valid", 32'(busy), 32'd1);
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", out_data);
                    end else begin
                        check("byte_stream", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                    byte_pos++;
                    if (byte_pos == PKT_LEN) begin
                        byte_pos = 0;
                        completed++;
                    end
                end
                prev_data  = out_data;
                prev_valid = out_valid;
                have_prev  = 1;
            end
        end
    end

    initial begin
        int base;
        int c;
        // Reset values
        tick(1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst = 1'b0;
        clear_model();

        // Single sample with the serializer model; latency of the first offer.
        ser_mode = 0;
        tick(2);
        strobe(16'h1234, 1'b1);
        tick(2);
        check("latency_not_before_3", 32'(out_valid), 32'd0);
        tick(1);
        check("latency_sync_at_3", 32'(out_valid), 32'd1);
        check("latency_sync_data", 32'(out_data), 32'hA5);
        wait_bytes(5, 400);
        for (int i = 0; i < 5; i++) check("pkt_1234_literal", 32'(got_q[i]), 32'(lit_a[i]));
        tick(12);
        check("busy_after_chk", 32'(busy), 32'd0);

        // Two samples two cycles apart.
        do_reset();
        strobe(16'h1234, 1'b1);
        tick(1);
        strobe(16'hBEEF, 1'b1);
        wait_bytes(10, 800);
        for (int i = 0; i < 5; i++) check("pkt_pair_first", 32'(got_q[i]), 32'(lit_a[i]));
        for (int i = 0; i < 5; i++) check("pkt_pair_second", 32'(got_q[5 + i]), 32'(lit_b[i]));
        check("pair_drop_count", 32'(drop_count), 32'd0);

        // Six strobes with ready low: one popped, four queued, one dropped.
        do_reset();
        ser_mode = 1;
        tick(2);
        for (int i = 0; i < 6; i++) strobe(SAMPLE_W'($urandom), i < 5);
        tick(2);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_drop_count", 32'(drop_count), 32'd1);
        ser_mode = 0;
        wait_bytes(25, 2000);
        for (int k = 0; k < 5; k++) check("ovf_seq_order", 32'(got_q[k * PKT_LEN + 1]), 32'(k));
        tick(30);
        check("ovf_no_extra_bytes", 32'(got_q.size()), 32'd25);

        // Ready stuck high: parks in HOLD after SYNC; a one-cycle low pulse releases SEQ.
        do_reset();
        ser_mode = 2;
        tick(2);
        strobe(SAMPLE_W'($urandom), 1'b1);
        tick(30);
        check("stall_one_byte", 32'(got_q.size()), 32'd1);
        check("stall_out_data", 32'(out_data), 32'hA5);
        check("stall_out_valid", 32'(out_valid), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        ser_mode = 1;
        tick(1);
        ser_mode = 2;
        tick(20);
        check("pulse_two_bytes", 32'(got_q.size()), 32'd2);
        check("pulse_seq_byte", 32'(got_q[1]), 32'h00);
        ser_mode = 1;
        tick(1);
        ser_mode = 0;
        wait_bytes(5, 400);

        // 257 random packets with random ready; FIFO never overfilled.
        do_reset();
        ser_mode = 3;
        c = 0;
        while (accepted < 257 && c < 30000) begin
            if (accepted - completed < FIFO_DEPTH && $urandom_range(0, 3) == 0)
                strobe(SAMPLE_W'($urandom), 1'b1);
            else
                tick(1);
            c++;
        end
        wait_bytes(257 * PKT_LEN, 30000);
        check("wrap_seq_first", 32'(got_q[1]), 32'h00);
        check("wrap_seq_255", 32'(got_q[255 * PKT_LEN + 1]), 32'hFF);
        check("wrap_seq_256", 32'(got_q[256 * PKT_LEN + 1]), 32'h00);
        check("random_drop_count", 32'(drop_count), 32'd0);
        tick(40);
        check("random_idle", 32'(busy), 32'd0);

        // Saturating drop counter.
        ser_mode = 1;
        tick(2);
        for (int i = 0; i < 305; i++) strobe(SAMPLE_W'($urandom), i < 5);
        tick(2);
        check("sat_overflow", 32'(overflow), 32'd1);
        check("sat_drop_count", 32'(drop_count), 32'd255);

        // Asynchronous reset mid-cycle while the third byte is held.
        base = got_q.size();
        ser_mode = 0;
        wait_bytes(base + 3, 400);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_drop_count", 32'(drop_count), 32'd0);
        check("arst_out_data", 32'(out_data), 32'h00);
        tick(1);
        rst = 1'b0;
        tick(1);
        strobe(16'h00FF, 1'b1);
        wait_bytes(5, 400);
        for (int i = 0; i < 5; i++) check("post_rst_pkt", 32'(got_q[i]), 32'(lit_c[i]));
        tick(12);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
